// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin selector.
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n channels, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_mux_arb.sv
// Combinational round-robin search: first requester at or after ptr, wrapping mod N.
module rr_arb
  import rr_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int CH_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel W-bit selector with fixed or round-robin grant and a registered valid/ready output.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int CNT_W = 16,
  localparam int CH_W  = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  input  logic [CH_W-1:0]  sel,
  input  logic             mode_rr,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [CH_W-1:0]  out_ch,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic            load;
  logic            arb_valid;
  logic [CH_W-1:0] arb_idx;
  logic            fixed_valid;
  logic            grant_valid;
  logic [CH_W-1:0] grant;
  logic [W-1:0]    grant_data;
  logic [CH_W-1:0] rr_ptr;

  assign load = !out_valid | out_ready;

  rr_arb #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Compare against every legal index so an out-of-range sel simply never matches.
  always_comb begin
    fixed_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == CH_W'(i) && in_valid[i]) fixed_valid = 1'b1;
    end
  end

  always_comb begin
    if (mode_rr == MODE_FIXED) begin
      grant_valid = load & fixed_valid;
      grant       = sel;
    end else begin
      grant_valid = load & arb_valid;
      grant       = arb_idx;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == CH_W'(i)) grant_data = in_data[i*W +: W];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = rst_n & grant_valid & (grant == CH_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        xfer_cnt  <= xfer_cnt + CNT_W'(1);
        if (mode_rr == MODE_RR) begin
          rr_ptr <= (grant == CH_W'(N - 1)) ? '0 : grant + CH_W'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed checks of rr_mux: reset, fixed select, round-robin order/skip, backpressure, counter wrap.
module tb_rr_mux;
  localparam int N = 4, W = 8, CNT_W = 4, CH_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic [CH_W-1:0]  sel;
  logic             mode_rr;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  rr_mux #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sel(sel), .mode_rr(mode_rr), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; sel = '0; mode_rr = 1'b1; out_ready = 1'b1;
    set_data();
    tick(); tick();
    chk("rst0_out_valid", 32'(out_valid), 32'd0);
    chk("rst0_in_ready", 32'(in_ready), 32'd0);
    chk("rst0_xfer_cnt", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;

    // RR fairness: all channels valid, consumer always ready
    in_valid = 4'b1111;
    #1 chk("rr_first_ready", 32'(in_ready), 32'b0001);
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_cnt = (exp_cnt + 1) % 16;
      chk("rr_seq_ch", 32'(out_ch), 32'(k % 4));
      chk("rr_seq_data", 32'(out_data), 32'(8'h10 + 8'(k % 4)));
      chk("rr_seq_valid", 32'(out_valid), 32'd1);
    end
    chk("rr_cnt5", 32'(xfer_cnt), 32'd5);

    // RR skip: pointer now 1, only ch0 and ch2 request
    in_valid = 4'b0101;
    #1 chk("skip_ready_a", 32'(in_ready), 32'b0100);
    tick(); chk("skip_ch_a", 32'(out_ch), 32'd2);
    chk("skip_ready_b", 32'(in_ready), 32'b0001);
    tick(); chk("skip_ch_b", 32'(out_ch), 32'd0);
    chk("skip_ready_c", 32'(in_ready), 32'b0100);
    tick(); chk("skip_ch_c", 32'(out_ch), 32'd2);
    chk("skip_cnt", 32'(xfer_cnt), 32'd8);

    // Backpressure: output word held, no input accepted
    out_ready = 1'b0;
    #1 chk("bp_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ch", 32'(out_ch), 32'd2);
      chk("bp_data", 32'(out_data), 32'h12);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_cnt", 32'(xfer_cnt), 32'd8);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'b0001);
    tick();
    chk("bp_release_ch", 32'(out_ch), 32'd0);
    chk("bp_release_data", 32'(out_data), 32'h10);
    chk("bp_release_cnt", 32'(xfer_cnt), 32'd9);

    // Fixed mode: sel=1 among two valid channels
    mode_rr = 1'b0; sel = 2'd1; in_valid = 4'b0011; in_data[1*W +: W] = 8'hA5;
    #1 chk("fix_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_ch", 32'(out_ch), 32'd1);
    chk("fix_cnt", 32'(xfer_cnt), 32'd10);

    // Fixed mode, selected channel idle: no grant, output goes invalid, data held
    sel = 2'd3;
    #1 chk("fix_idle_ready", 32'(in_ready), 32'd0);
    tick();
    chk("fix_idle_valid", 32'(out_valid), 32'd0);
    chk("fix_idle_data", 32'(out_data), 32'hA5);
    chk("fix_idle_ch", 32'(out_ch), 32'd1);
    chk("fix_idle_cnt", 32'(xfer_cnt), 32'd10);

    // Reset while a word is pending and all channels request
    set_data(); mode_rr = 1'b1; in_valid = 4'b1111;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 32'b0001);

    // Counter wrap with a 4-bit counter over 17 transfers
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("wrap_ch", 32'(out_ch), 32'((k - 1) % 4));
      if (k == 16) chk("wrap_cnt16", 32'(xfer_cnt), 32'd0);
      if (k == 17) chk("wrap_cnt17", 32'(xfer_cnt), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
